// File: rtl/arbitro_escrita.sv
// arbitro_escrita: writeback arbiter and pending-register scoreboard.
// Single-cycle ALU results have absolute priority on the register-file write port.
// Slow results (loads, mul/div) arrive on a valid/ready handshake and wait in a
// small FIFO. The FIFO drains whenever the ALU is idle; an ALU result to x0 counts as idle.
// The pendente vector marks destination registers with a write still outstanding,
// so decode can stall on RAW/WAW hazards.
// Optional feature macro: ARBITRO_BYPASS_EN. When it is defined, a slow result that
// arrives while the FIFO is empty and the ALU is idle skips the FIFO and is written
// one cycle after acceptance.
module arbitro_escrita #(
    parameter int PROFUNDIDADE = 4,
    parameter int LARGURA      = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alu_valido,
    input  logic [4:0]         alu_regd,
    input  logic [LARGURA-1:0] alu_dado,
    input  logic               mem_valido,
    input  logic [4:0]         mem_regd,
    input  logic [LARGURA-1:0] mem_dado,
    output logic               mem_pronto,
    input  logic               emite_valido,
    input  logic [4:0]         emite_regd,
    output logic               reg_escrita,
    output logic [4:0]         endereco_regd,
    output logic [LARGURA-1:0] dado_escrita,
    output logic [31:0]        pendente,
    output logic               fila_vazia,
    output logic               fila_cheia
);

    localparam int AW = $clog2(PROFUNDIDADE);
    localparam logic [AW:0] CONT_CHEIA = (AW + 1)'(PROFUNDIDADE);

    // FIFO storage, written on push; not reset, since the pointers define validity
    logic [LARGURA-1:0] fila_dado_mem [PROFUNDIDADE];
    logic [4:0]         fila_regd_mem [PROFUNDIDADE];

    logic [AW-1:0] ptr_esc_q, ptr_esc_d;
    logic [AW-1:0] ptr_lei_q, ptr_lei_d;
    logic [AW:0]   contagem_q, contagem_d;

    logic               reg_escrita_q, reg_escrita_d;
    logic [4:0]         endereco_q, endereco_d;
    logic [LARGURA-1:0] dado_q, dado_d;
    logic [31:0]        pendente_q, pendente_d;

    logic alu_ativo;
    logic aceita_mem;
    logic mem_util;
    logic desvio;
    logic empilha;
    logic desempilha;

    logic [31:0] marca_vec;
    logic [31:0] limpa_vec;

    assign fila_vazia = (contagem_q == '0);
    assign fila_cheia = (contagem_q == CONT_CHEIA);

    // Readiness looks only at full, so a same-cycle pop never reopens a full FIFO
    assign mem_pronto = ~fila_cheia & ~reset;

    assign reg_escrita   = reg_escrita_q;
    assign endereco_regd = endereco_q;
    assign dado_escrita  = dado_q;
    assign pendente      = pendente_q;

    // Arbitration decisions for this cycle
    always_comb begin
        alu_ativo  = alu_valido && (alu_regd != 5'd0);
        aceita_mem = mem_valido && mem_pronto;
        // A result destined for x0 completes its handshake but is dropped
        mem_util   = aceita_mem && (mem_regd != 5'd0);
`ifdef ARBITRO_BYPASS_EN
        desvio     = mem_util && fila_vazia && !alu_ativo;
`else
        desvio     = 1'b0;
`endif
        empilha    = mem_util && !desvio;
        desempilha = !alu_ativo && !fila_vazia;
    end

    // Next-state for the FIFO pointers and occupancy count
    always_comb begin
        ptr_esc_d  = ptr_esc_q;
        ptr_lei_d  = ptr_lei_q;
        contagem_d = contagem_q;
        if (empilha) begin
            ptr_esc_d = ptr_esc_q + AW'(1);
        end
        if (desempilha) begin
            ptr_lei_d = ptr_lei_q + AW'(1);
        end
        case ({empilha, desempilha})
            2'b10:   contagem_d = contagem_q + (AW + 1)'(1);
            2'b01:   contagem_d = contagem_q - (AW + 1)'(1);
            default: contagem_d = contagem_q;
        endcase
    end

    // Write-port selection: ALU first, then the FIFO head, then a bypassed slow result
    always_comb begin
        reg_escrita_d = 1'b0;
        endereco_d    = endereco_q;
        dado_d        = dado_q;
        if (alu_ativo) begin
            reg_escrita_d = 1'b1;
            endereco_d    = alu_regd;
            dado_d        = alu_dado;
        end else if (desempilha) begin
            reg_escrita_d = 1'b1;
            endereco_d    = fila_regd_mem[ptr_lei_q];
            dado_d        = fila_dado_mem[ptr_lei_q];
        end else if (desvio) begin
            reg_escrita_d = 1'b1;
            endereco_d    = mem_regd;
            dado_d        = mem_dado;
        end
    end

    // Per-register set/clear terms; x0 can never be marked pending
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_marca
            if (gi == 0) begin : g_zero
                assign marca_vec[gi] = 1'b0;
                assign limpa_vec[gi] = 1'b0;
            end else begin : g_reg
                assign marca_vec[gi] = emite_valido && (emite_regd == 5'(gi));
                assign limpa_vec[gi] = reg_escrita_q && (endereco_q == 5'(gi));
            end
        end
    endgenerate

    // Scoreboard update: an issue on the same edge as the write keeps the bit set
    always_comb begin
        pendente_d    = (pendente_q & ~limpa_vec) | marca_vec;
        pendente_d[0] = 1'b0;
    end

    // FIFO storage write
    always_ff @(posedge clock) begin
        if (empilha) begin
            fila_dado_mem[ptr_esc_q] <= mem_dado;
            fila_regd_mem[ptr_esc_q] <= mem_regd;
        end
    end

    // State registers; reset flushes the FIFO, the write port and the scoreboard
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_esc_q     <= '0;
            ptr_lei_q     <= '0;
            contagem_q    <= '0;
            reg_escrita_q <= 1'b0;
            endereco_q    <= '0;
            dado_q        <= '0;
            pendente_q    <= '0;
        end else begin
            ptr_esc_q     <= ptr_esc_d;
            ptr_lei_q     <= ptr_lei_d;
            contagem_q    <= contagem_d;
            reg_escrita_q <= reg_escrita_d;
            endereco_q    <= endereco_d;
            dado_q        <= dado_d;
            pendente_q    <= pendente_d;
        end
    end

endmodule

// File: tb/tb_arbitro_escrita.sv
// tb_arbitro_escrita: directed stimulus with a write scoreboard for arbitro_escrita.
// Stimulus pushes each expected register-file write (cycle, register, data) into a queue.
// A monitor pops and compares an entry whenever reg_escrita is high.
module tb_arbitro_escrita;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valido;
    logic [4:0]  alu_regd;
    logic [31:0] alu_dado;
    logic        mem_valido;
    logic [4:0]  mem_regd;
    logic [31:0] mem_dado;
    logic        mem_pronto;
    logic        emite_valido;
    logic [4:0]  emite_regd;
    logic        reg_escrita;
    logic [4:0]  endereco_regd;
    logic [31:0] dado_escrita;
    logic [31:0] pendente;
    logic        fila_vazia;
    logic        fila_cheia;

    typedef struct {
        int          c;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    arbitro_escrita #(.PROFUNDIDADE(4), .LARGURA(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .alu_valido    (alu_valido),
        .alu_regd      (alu_regd),
        .alu_dado      (alu_dado),
        .mem_valido    (mem_valido),
        .mem_regd      (mem_regd),
        .mem_dado      (mem_dado),
        .mem_pronto    (mem_pronto),
        .emite_valido  (emite_valido),
        .emite_regd    (emite_regd),
        .reg_escrita   (reg_escrita),
        .endereco_regd (endereco_regd),
        .dado_escrita  (dado_escrita),
        .pendente      (pendente),
        .fila_vazia    (fila_vazia),
        .fila_cheia    (fila_cheia)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_write(input int c, input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.c = c;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        alu_valido   = 1'b0;
        mem_valido   = 1'b0;
        emite_valido = 1'b0;
    endtask

    // Monitor: one line per observed write, compared against the queue head
    always @(negedge clock) begin
        if (reg_escrita === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=r%0d:%h required=none (cycle %0d)",
                         endereco_regd, dado_escrita, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("write cycle=%0d r%0d=%h", cyc, endereco_regd, dado_escrita);
                check("write_cycle", cyc, e.c);
                check("write_reg", 32'(endereco_regd), 32'(e.r));
                check("write_data", dado_escrita, e.d);
            end
        end
    end

    initial begin
        int idx;
        int c0;
        logic pr;

        reset = 1'b1;
        idle();
        alu_regd = 5'd0; alu_dado = '0;
        mem_regd = 5'd0; mem_dado = '0;
        emite_regd = 5'd0;
        step();
        step();
        check("rst_reg_escrita", 32'(reg_escrita), 32'd0);
        check("rst_fila_vazia", 32'(fila_vazia), 32'd1);
        check("rst_mem_pronto", 32'(mem_pronto), 32'd0);
        check("rst_pendente", pendente, 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_mem_pronto", 32'(mem_pronto), 32'd1);

        // ALU write appears for exactly one cycle, then address/data hold
        alu_valido = 1'b1; alu_regd = 5'd5; alu_dado = 32'hDEADBEEF;
        expect_write(cyc + 1, 5'd5, 32'hDEADBEEF);
        step();
        idle();
        step();
        check("hold_reg_escrita", 32'(reg_escrita), 32'd0);
        check("hold_endereco", 32'(endereco_regd), 32'd5);
        check("hold_dado", dado_escrita, 32'hDEADBEEF);

        // ALU and slow result together: ALU first, slow result one cycle later
        alu_valido = 1'b1; alu_regd = 5'd3; alu_dado = 32'h11;
        mem_valido = 1'b1; mem_regd = 5'd4; mem_dado = 32'h22;
        expect_write(cyc + 1, 5'd3, 32'h11);
        expect_write(cyc + 2, 5'd4, 32'h22);
        step();
        idle();
        step();
        step();

        // ALU to x0 lets the FIFO head r9 drain
        alu_valido = 1'b1; alu_regd = 5'd1; alu_dado = 32'h33;
        mem_valido = 1'b1; mem_regd = 5'd9; mem_dado = 32'h55;
        expect_write(cyc + 1, 5'd1, 32'h33);
        step();
        mem_valido = 1'b0;
        alu_valido = 1'b1; alu_regd = 5'd0; alu_dado = 32'hBAD;
        expect_write(cyc + 1, 5'd9, 32'h55);
        step();
        idle();
        step();

        // Slow result to x0 is accepted but never written or counted
        mem_valido = 1'b1; mem_regd = 5'd0; mem_dado = 32'h99;
        step();
        mem_valido = 1'b0;
        check("x0_fila_vazia", 32'(fila_vazia), 32'd1);
        step();
        step();

        // Continuous ALU traffic fills the FIFO; an x0 push first must not count
        idx = 0;
        for (int k = 0; k < 9; k++) begin
            alu_valido = 1'b1; alu_regd = 5'd1; alu_dado = 32'h100 + 32'(k);
            expect_write(cyc + 1, 5'd1, 32'h100 + 32'(k));
            mem_valido = 1'b1;
            mem_regd   = (idx == 0) ? 5'd0 : 5'(9 + idx);
            mem_dado   = 32'hA0 + 32'(idx) - 32'd1;
            pr = mem_pronto;
            step();
            if (pr && idx < 5) idx++;
        end
        check("full_mem_pronto", 32'(mem_pronto), 32'd0);
        check("full_fila_cheia", 32'(fila_cheia), 32'd1);
        // ALU stops: A0..A3 drain, A4 (held) enters and follows without a gap
        alu_valido = 1'b0;
        c0 = cyc;
        for (int k = 0; k < 5; k++) expect_write(c0 + 1 + k, 5'(10 + k), 32'hA0 + 32'(k));
        step();
        check("drain_mem_pronto", 32'(mem_pronto), 32'd1);
        step();
        mem_valido = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("drain_fila_vazia", 32'(fila_vazia), 32'd1);

        // Scoreboard set, clear, and set-wins-on-same-edge
        emite_valido = 1'b1; emite_regd = 5'd7;
        step();
        emite_valido = 1'b0;
        check("pend_set", pendente, 32'h80);
        alu_valido = 1'b1; alu_regd = 5'd7; alu_dado = 32'h70;
        expect_write(cyc + 1, 5'd7, 32'h70);
        step();
        alu_valido = 1'b0;
        check("pend_before_clear", pendente, 32'h80);
        step();
        check("pend_clear", pendente, 32'h0);
        emite_valido = 1'b1; emite_regd = 5'd7;
        step();
        emite_valido = 1'b0;
        alu_valido = 1'b1; alu_regd = 5'd7; alu_dado = 32'h71;
        expect_write(cyc + 1, 5'd7, 32'h71);
        step();
        alu_valido = 1'b0;
        emite_valido = 1'b1; emite_regd = 5'd7;
        step();
        check("pend_set_wins", pendente, 32'h80);
        emite_regd = 5'd0;
        step();
        emite_valido = 1'b0;
        check("pend_x0_ignored", pendente, 32'h80);
        alu_valido = 1'b1; alu_regd = 5'd7; alu_dado = 32'h72;
        expect_write(cyc + 1, 5'd7, 32'h72);
        step();
        alu_valido = 1'b0;
        step();
        check("pend_clear2", pendente, 32'h0);

        // Lone slow result with an empty FIFO and idle ALU
        mem_valido = 1'b1; mem_regd = 5'd6; mem_dado = 32'h77;
`ifdef ARBITRO_BYPASS_EN
        expect_write(cyc + 1, 5'd6, 32'h77);
`else
        expect_write(cyc + 2, 5'd6, 32'h77);
`endif
        step();
        mem_valido = 1'b0;
`ifdef ARBITRO_BYPASS_EN
        check("bypass_fila_vazia", 32'(fila_vazia), 32'd1);
`else
        check("lone_fila_vazia", 32'(fila_vazia), 32'd0);
`endif
        step();
        step();

        // Reset mid-traffic: buffered r13 and pending r12 are lost
        emite_valido = 1'b1; emite_regd = 5'd12;
        alu_valido = 1'b1; alu_regd = 5'd2; alu_dado = 32'h2;
        mem_valido = 1'b1; mem_regd = 5'd13; mem_dado = 32'h13;
        expect_write(cyc + 1, 5'd2, 32'h2);
        step();
        emite_valido = 1'b0;
        mem_valido = 1'b0;
        alu_dado = 32'h3;
        reset = 1'b1;
        #1;
        check("rst_mid_mem_pronto_a", 32'(mem_pronto), 32'd0);
        step();
        alu_valido = 1'b0;
        check("rst_mid_reg_escrita", 32'(reg_escrita), 32'd0);
        check("rst_mid_endereco", 32'(endereco_regd), 32'd0);
        check("rst_mid_dado", dado_escrita, 32'd0);
        check("rst_mid_pendente", pendente, 32'd0);
        check("rst_mid_fila_vazia", 32'(fila_vazia), 32'd1);
        check("rst_mid_fila_cheia", 32'(fila_cheia), 32'd0);
        check("rst_mid_mem_pronto_b", 32'(mem_pronto), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("rst_mid_after_pronto", 32'(mem_pronto), 32'd1);
        check("rst_mid_after_vazia", 32'(fila_vazia), 32'd1);
        for (int k = 0; k < 4; k++) step();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("expected_writes_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
